// File: rtl/neural_argmax_seven.sv
// Streaming argmax over one frame of class scores, with a best/second-best margin flag
// and a seven-segment rendering of the winning class index.
module neural_argmax_seven #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter int SIGNED      = 0,
    parameter int MARGIN      = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              score_valid,
    input  logic [DATA_W-1:0] score_in,
    output logic              score_ready,
    output logic              result_valid,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_score,
    output logic              low_conf,
    output logic              busy,
    output logic [7:0]        seven_seg
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [DATA_W-1:0] MIN_V    = (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [DATA_W:0]   MARGIN_V = (DATA_W+1)'(MARGIN);

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    // One extra bit so the difference of extreme scores cannot wrap.
    function automatic logic [DATA_W:0] span(input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
        logic [DATA_W:0] h;
        logic [DATA_W:0] l;
        if (SIGNED != 0) begin
            h = {hi[DATA_W-1], hi};
            l = {lo[DATA_W-1], lo};
        end else begin
            h = {1'b0, hi};
            l = {1'b0, lo};
        end
        return h - l;
    endfunction

    function automatic logic [7:0] seg_code(input logic [IDX_W-1:0] idx, input logic dp);
        logic [6:0] s;
        case (32'(idx))
            0:       s = 7'h3F;
            1:       s = 7'h06;
            2:       s = 7'h5B;
            3:       s = 7'h4F;
            4:       s = 7'h66;
            5:       s = 7'h6D;
            6:       s = 7'h7D;
            7:       s = 7'h07;
            8:       s = 7'h7F;
            9:       s = 7'h6F;
            default: s = 7'h40;
        endcase
        return {dp, s};
    endfunction

    state_t              state_q;
    logic [IDX_W-1:0]    count_q;
    logic [DATA_W-1:0]   best_q, second_q;
    logic [IDX_W-1:0]    best_idx_q;
    logic [DATA_W-1:0]   best_d, second_d;
    logic [IDX_W-1:0]    best_idx_d;
    logic [DATA_W:0]     diff;
    logic                low_conf_d;
    logic                accept;
    logic                last_beat;

    logic                result_valid_q;
    logic [IDX_W-1:0]    class_idx_q;
    logic [DATA_W-1:0]   max_score_q;
    logic                low_conf_q;
    logic [7:0]          seven_seg_q;

    assign score_ready = !clear && (state_q != DONE);
    assign accept      = score_valid && score_ready;
    assign last_beat   = (count_q == LAST_IDX);

    // Running best/second including the beat on the input this cycle.
    always_comb begin
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        if (state_q == IDLE) begin
            best_d     = score_in;
            best_idx_d = '0;
            second_d   = MIN_V;
        end else if (gt(score_in, best_q)) begin
            second_d   = best_q;
            best_d     = score_in;
            best_idx_d = count_q;
        end else if (gt(score_in, second_q)) begin
            second_d   = score_in;
        end
    end

    assign diff       = span(best_d, second_d);
    assign low_conf_d = (MARGIN != 0) && (diff < MARGIN_V);

    always_ff @(posedge clk) begin
        if (accept) begin
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            class_idx_q    <= '0;
            max_score_q    <= '0;
            low_conf_q     <= 1'b0;
            seven_seg_q    <= 8'h00;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE, ACCUM: begin
                    if (clear) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (accept) begin
                        if (last_beat) begin
                            state_q        <= DONE;
                            count_q        <= '0;
                            result_valid_q <= 1'b1;
                            class_idx_q    <= best_idx_d;
                            max_score_q    <= best_d;
                            low_conf_q     <= low_conf_d;
                            seven_seg_q    <= seg_code(best_idx_d, low_conf_d);
                        end else begin
                            state_q <= ACCUM;
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign result_valid = result_valid_q;
    assign class_idx    = class_idx_q;
    assign max_score    = max_score_q;
    assign low_conf     = low_conf_q;
    assign seven_seg    = seven_seg_q;
    assign busy         = (state_q == ACCUM);

endmodule

// File: tb/tb_neural_argmax_seven.sv
// Directed-vector bench: three instances (unsigned MARGIN=32, unsigned MARGIN=1, signed MARGIN=0)
// share one score stream; each frame record carries hand-computed results for every instance.
module tb_neural_argmax_seven;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, clear, score_valid;
    logic [15:0] score_in;

    logic        rdy_a, rv_a, lc_a, busy_a;
    logic [3:0]  idx_a;
    logic [15:0] max_a;
    logic [7:0]  seg_a;
    logic        rdy_c, rv_c, lc_c, busy_c;
    logic [3:0]  idx_c;
    logic [15:0] max_c;
    logic [7:0]  seg_c;
    logic        rdy_s, rv_s, lc_s, busy_s;
    logic [3:0]  idx_s;
    logic [15:0] max_s;
    logic [7:0]  seg_s;

    neural_argmax_seven #(.DATA_W(16), .NUM_CLASSES(10), .IDX_W(4), .SIGNED(0), .MARGIN(32)) u_a (
        .clk(clk), .n_rst(n_rst), .clear(clear), .score_valid(score_valid), .score_in(score_in),
        .score_ready(rdy_a), .result_valid(rv_a), .class_idx(idx_a), .max_score(max_a),
        .low_conf(lc_a), .busy(busy_a), .seven_seg(seg_a));

    neural_argmax_seven #(.DATA_W(16), .NUM_CLASSES(10), .IDX_W(4), .SIGNED(0), .MARGIN(1)) u_c (
        .clk(clk), .n_rst(n_rst), .clear(clear), .score_valid(score_valid), .score_in(score_in),
        .score_ready(rdy_c), .result_valid(rv_c), .class_idx(idx_c), .max_score(max_c),
        .low_conf(lc_c), .busy(busy_c), .seven_seg(seg_c));

    neural_argmax_seven #(.DATA_W(16), .NUM_CLASSES(10), .IDX_W(4), .SIGNED(1), .MARGIN(0)) u_s (
        .clk(clk), .n_rst(n_rst), .clear(clear), .score_valid(score_valid), .score_in(score_in),
        .score_ready(rdy_s), .result_valid(rv_s), .class_idx(idx_s), .max_score(max_s),
        .low_conf(lc_s), .busy(busy_s), .seven_seg(seg_s));

    typedef struct {
        logic [9:0][15:0] sc;
        logic [3:0]       e_idx_u;
        logic [15:0]      e_max_u;
        logic [7:0]       e_seg_a;
        logic [7:0]       e_seg_c;
        logic [3:0]       e_idx_s;
        logic [15:0]      e_max_s;
        logic [7:0]       e_seg_s;
        bit               gaps;
    } vec_t;

    vec_t tv[6];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   pulses = 0;

    always @(negedge clk) if (rv_a) pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [159:0] flat, input logic [3:0] iu, input logic [15:0] mu,
                                 input logic [7:0] sa, input logic [7:0] sc, input logic [3:0] is_,
                                 input logic [15:0] ms, input logic [7:0] ss, input bit g);
        vec_t v;
        for (int i = 0; i < 10; i++) v.sc[i] = flat[159-16*i -: 16];
        v.e_idx_u = iu; v.e_max_u = mu; v.e_seg_a = sa; v.e_seg_c = sc;
        v.e_idx_s = is_; v.e_max_s = ms; v.e_seg_s = ss; v.gaps = g;
        return v;
    endfunction

    task automatic drive_beat(input logic [15:0] s, input int gap);
        score_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        score_valid = 1'b1;
        score_in    = s;
        @(posedge clk); #1;
        score_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int p0;
        int gap;
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            gap = v.gaps ? int'($urandom_range(0, 2)) : 0;
            if (i == 9) chk({tag, " rv_before_last"}, 32'(rv_a), 32'd0);
            drive_beat(v.sc[i], gap);
            if (i == 0) chk({tag, " busy_after_first"}, 32'(busy_a), 32'd1);
        end
        chk({tag, " rv_a"},  32'(rv_a), 32'd1);
        chk({tag, " rv_c"},  32'(rv_c), 32'd1);
        chk({tag, " rv_s"},  32'(rv_s), 32'd1);
        chk({tag, " rdy_done"}, 32'(rdy_a), 32'd0);
        chk({tag, " idx_a"}, 32'(idx_a), 32'(v.e_idx_u));
        chk({tag, " max_a"}, 32'(max_a), 32'(v.e_max_u));
        chk({tag, " lc_a"},  32'(lc_a),  32'(v.e_seg_a[7]));
        chk({tag, " seg_a"}, 32'(seg_a), 32'(v.e_seg_a));
        chk({tag, " idx_c"}, 32'(idx_c), 32'(v.e_idx_u));
        chk({tag, " max_c"}, 32'(max_c), 32'(v.e_max_u));
        chk({tag, " lc_c"},  32'(lc_c),  32'(v.e_seg_c[7]));
        chk({tag, " seg_c"}, 32'(seg_c), 32'(v.e_seg_c));
        chk({tag, " idx_s"}, 32'(idx_s), 32'(v.e_idx_s));
        chk({tag, " max_s"}, 32'(max_s), 32'(v.e_max_s));
        chk({tag, " lc_s"},  32'(lc_s),  32'(v.e_seg_s[7]));
        chk({tag, " seg_s"}, 32'(seg_s), 32'(v.e_seg_s));
        @(posedge clk); #1;
        chk({tag, " rv_drop"},   32'(rv_a),   32'd0);
        chk({tag, " busy_idle"}, 32'(busy_a), 32'd0);
        chk({tag, " rdy_idle"},  32'(rdy_a),  32'd1);
        chk({tag, " idx_held"},  32'(idx_a),  32'(v.e_idx_u));
        chk({tag, " pulse_cnt"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        tv[0] = mkv({16'h07F2,16'h01BB,16'h00BF,16'h01D7,16'h0065,16'h0208,16'h001A,16'h0037,16'h001F,16'h0017},
                    4'd0, 16'h07F2, 8'h3F, 8'h3F, 4'd0, 16'h07F2, 8'h3F, 1'b0);
        tv[1] = mkv({16'h00C5,16'h002F,16'h0104,16'h0018,16'h0F26,16'h0012,16'h0026,16'h005C,16'h002A,16'h00E9},
                    4'd4, 16'h0F26, 8'h66, 8'h66, 4'd4, 16'h0F26, 8'h66, 1'b1);
        tv[2] = mkv({16'h01F2,16'h01BB,16'h00BF,16'h01D7,16'h0065,16'h0208,16'h001A,16'h0037,16'h001F,16'h0017},
                    4'd5, 16'h0208, 8'hED, 8'h6D, 4'd5, 16'h0208, 8'h6D, 1'b0);
        tv[3] = mkv({16'h0010,16'h0010,16'h0010,16'h0500,16'h0010,16'h0010,16'h0010,16'h0500,16'h0010,16'h0010},
                    4'd3, 16'h0500, 8'hCF, 8'hCF, 4'd3, 16'h0500, 8'h4F, 1'b0);
        tv[4] = mkv({16'h0100,16'h8000,16'h0200,16'h0050,16'h0050,16'h0050,16'h0050,16'h0050,16'h0050,16'h0050},
                    4'd1, 16'h8000, 8'h06, 8'h06, 4'd2, 16'h0200, 8'h5B, 1'b0);
        tv[5] = mkv({16'hFF00,16'hFE00,16'hF000,16'h8000,16'hFF00,16'hFE80,16'hFC00,16'hFF00,16'hFFFE,16'hF800},
                    4'd8, 16'hFFFE, 8'h7F, 8'h7F, 4'd8, 16'hFFFE, 8'h7F, 1'b0);

        n_rst = 1'b0; clear = 1'b0; score_valid = 1'b0; score_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst rv",   32'(rv_a),   32'd0);
        chk("rst idx",  32'(idx_a),  32'd0);
        chk("rst max",  32'(max_a),  32'd0);
        chk("rst lc",   32'(lc_a),   32'd0);
        chk("rst busy", 32'(busy_a | busy_c | busy_s), 32'd0);
        chk("rst seg",  32'(seg_a),  32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst ready", 32'({rdy_a, rdy_c, rdy_s}), 32'h7);

        for (int k = 0; k < 6; k++) run_frame(tv[k], $sformatf("vec%0d", k));

        // Abort: clear after four beats, then reset six beats into the next frame.
        begin
            int p0;
            p0 = pulses;
            for (int i = 0; i < 4; i++) drive_beat(tv[0].sc[i], 0);
            clear = 1'b1; score_valid = 1'b1; score_in = 16'hFFFF;
            #1;
            chk("clr ready", 32'(rdy_a), 32'd0);
            @(posedge clk); #1;
            clear = 1'b0; score_valid = 1'b0;
            chk("clr busy", 32'(busy_a), 32'd0);
            chk("clr idx",  32'(idx_a),  32'd8);
            chk("clr max",  32'(max_a),  32'hFFFE);
            chk("clr seg",  32'(seg_a),  32'h7F);
            for (int i = 0; i < 6; i++) drive_beat(tv[1].sc[i], 0);
            chk("mid busy", 32'(busy_a), 32'd1);
            n_rst = 1'b0;
            #1;
            chk("arst idx",  32'(idx_s),  32'd0);
            chk("arst max",  32'(max_s),  32'd0);
            chk("arst seg",  32'(seg_s),  32'd0);
            chk("arst busy", 32'(busy_a), 32'd0);
            #1;
            n_rst = 1'b1;
            @(posedge clk); #1;
            chk("abort pulses", 32'(pulses - p0), 32'd0);
        end

        run_frame(tv[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
